player_action_ctrl: RTL and testbench
=====================================

# player_action_ctrl

Per-player action sequencer between the debounced button inputs and the player's PhysicsEngine instance. It turns raw left/right/jump/attack levels into the `movingLeft` / `movingRight` / `isJumping` commands the physics block samples. It enforces action lockouts (attack recovery, hit stun, knockout) and exposes the current action state to the renderer and hit-detection logic. It runs on the fast system clock and advances only on a one-cycle 20 Hz game-tick strobe, so the physics engine always sees commands that are stable across a full tick.

## Interface
Parameters:
- `ATTACK_TICKS`, 6: ticks an attack occupies, from entry tick to recovery; range 1–31.
- `STUN_TICKS`, 10: ticks of hit stun; range 1–31.
- `MIN_AIR_TICKS`, 2: minimum ticks in AIRBORNE before a landing is accepted; range 1–31.
- `FLOOR_Y`, 48: sprite y value that means the player is on the floor.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle game-tick strobe at 20 Hz.
- `enable`  in  1  round active; when low, motion commands are suppressed and the FSM is held in IDLE.
- `player_no`  in  1  0 = left player, 1 = right player.
- `btn_left`, `btn_right`, `btn_jump`, `btn_attack`  in  1 each  synchronised, debounced button levels.
- `sprite_y`  in  7  current y from the physics engine.
- `hit_taken`  in  1  one-cycle pulse from hit detection.
- `health_zero`  in  1  level signal; health is exhausted.
- `movingLeft`, `movingRight`, `isJumping`  out  1 each  commands to the physics engine.
- `attack_active`  out  1  hitbox enable.
- `facing_right`  out  1  sprite orientation.
- `state`  out  3  encoded FSM state.

## Operation
- States: IDLE, WALK, AIRBORNE, ATTACK, STUN, KO.
- On reset, all outputs are 0 except the following:
  - `facing_right` = ~`player_no`.
  - `state` = IDLE.
  - Counters are 0 and the hit-pending flag is 0.
- `hit_taken` may arrive on any cycle. It sets a sticky `hit_pend` flag, which is cleared on the next tick.
- All transitions and output updates happen only on `tick` cycles. Between ticks, outputs hold their values.
- Evaluation priority on each tick:
  1. `health_zero` sends the FSM to KO.
  2. Otherwise `enable` = 0 sends it to IDLE.
  3. Otherwise `hit_pend` sends it to STUN and loads the counter with `STUN_TICKS`.
  4. Otherwise the per-state rule applies.
- IDLE and WALK:
  - An attack rising edge sends the FSM to ATTACK and loads the counter with `ATTACK_TICKS`. The edge is `btn_attack` high on this tick and low on the previous tick.
  - Else if `btn_jump` is high and `sprite_y` == `FLOOR_Y`, the FSM goes to AIRBORNE, `isJumping` = 1 for this tick only, and the air counter is cleared.
  - Else if exactly one of `btn_left` / `btn_right` is high, the FSM goes to WALK and asserts that direction. `facing_right` follows the pressed direction.
  - Else the FSM goes to IDLE with no motion.
- AIRBORNE:
  - `isJumping` drops on the next tick.
  - Left/right air control follows the same xor rule as WALK.
  - The air counter increments and saturates at 31.
  - The FSM goes to IDLE when `sprite_y` == `FLOOR_Y` and the air counter ≥ `MIN_AIR_TICKS`.
- ATTACK:
  - No motion; `attack_active` = 1.
  - The counter decrements each tick. When it reaches 0, the FSM goes to IDLE.
- STUN:
  - No motion and `attack_active` = 0.
  - A new hit reloads `STUN_TICKS`.
  - When the counter reaches 0: IDLE if on the floor, otherwise AIRBORNE with the air counter set to `MIN_AIR_TICKS`.
- KO: all commands are 0. The state is sticky until reset; `enable` does not release it.
- Button edge history updates on every tick, including in locked states. A held attack button therefore cannot retrigger after ATTACK ends.

## Timing
- Latency from a button change to a command change: the next tick edge (at most one tick period).
- Commands are registered in the same `clk` cycle as `tick`, so they are stable for the following 20 Hz physics edge.
- When `hit_taken` and `tick` occur in the same cycle, the hit is counted for that tick.
- Counter widths are 5 bits. Decrement from 0 is never reached, because the 0 check happens first.
- Asynchronous reset during ATTACK, STUN or AIRBORNE forces IDLE immediately. `isJumping` deasserts without waiting for a tick.

## Structure
- Shared package `fighter_pkg` holds:
  - The state encoding: IDLE=0, WALK=1, AIRBORNE=2, ATTACK=3, STUN=4, KO=5.
  - `FLOOR_Y`.
  - The tick rate constant.
- Sub-module `action_timer`: a 5-bit loadable down-counter with a tick enable and a `done` flag. It is shared by ATTACK and STUN.
- The air counter stays inline.

## Test plan
- Reset with `player_no`=1 → `facing_right`=0, `state`=IDLE, all commands 0.
- `btn_right` held for 3 ticks → `movingRight`=1 from the first tick, `state`=WALK, `facing_right`=1. With both buttons held → no motion.
- `btn_jump` pulse with `sprite_y`=48:
  - `isJumping`=1 for exactly one tick.
  - `sprite_y` stays 48 on the next tick → still AIRBORNE.
  - Returns to IDLE on the first tick with `sprite_y`=48 after 2 air ticks.
- `btn_attack` held for 10 ticks → `attack_active`=1 for exactly 6 ticks, then IDLE, with no retrigger until the button is released and pressed again.
- `hit_taken` pulse between ticks during ATTACK → STUN on the next tick; a second hit 4 ticks later → STUN lasts 10 more ticks.
- `health_zero` asserted during AIRBORNE → KO on the next tick. Toggling `enable` → KO is kept; only `reset` low returns the FSM to IDLE.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared fighter definitions: action state encoding, counter widths,
// floor height and game-tick rate used by the per-player controllers.
package fighter_pkg;

   localparam int unsigned CNT_W   = 5;
   localparam int unsigned Y_W     = 7;
   localparam int unsigned FLOOR_Y = 48;
   localparam int unsigned TICK_HZ = 20;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WALK     = 3'd1,
      ST_AIRBORNE = 3'd2,
      ST_ATTACK   = 3'd3,
      ST_STUN     = 3'd4,
      ST_KO       = 3'd5
   } state_e;

endpackage

// File: rtl/action_timer.sv
// 5-bit loadable down-counter advanced on the game tick, shared by the
// attack-recovery and hit-stun lockouts.
//   clk, reset   : system clock, async active-low reset
//   tick         : game-tick strobe; counter only changes on tick cycles
//   load/load_val: reload the counter (wins over dec)
//   dec          : decrement by one, holding at zero
//   done_c       : this tick's decrement reaches (or sits at) zero
module action_timer
   import fighter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count
   always_comb begin
      cnt_d = cnt_q;
      if (tick) begin
         if (load) begin
            cnt_d = load_val;
         end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Lockout ends on the tick whose decrement lands on zero
   assign done_c = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer: converts debounced button levels into
// physics commands once per game tick, enforcing attack/stun/KO lockouts.
//   clk, reset        : system clock, async active-low reset
//   tick              : one-cycle 20 Hz game-tick strobe
//   enable            : round active; low holds IDLE with no motion
//   player_no         : 0 = left player, 1 = right player
//   btn_*             : synchronised, debounced button levels
//   sprite_y          : current y from the physics engine
//   hit_taken         : one-cycle hit pulse, any cycle
//   health_zero       : health exhausted (level)
//   movingLeft/Right, isJumping : physics commands
//   attack_active     : hitbox enable
//   facing_right      : sprite orientation
//   state             : encoded action state
module player_action_ctrl #(
   parameter int unsigned ATTACK_TICKS  = 6,
   parameter int unsigned STUN_TICKS    = 10,
   parameter int unsigned MIN_AIR_TICKS = 2,
   parameter int unsigned FLOOR_Y       = fighter_pkg::FLOOR_Y
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       enable,
   input  logic       player_no,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       btn_attack,
   input  logic [6:0] sprite_y,
   input  logic       hit_taken,
   input  logic       health_zero,
   output logic       movingLeft,
   output logic       movingRight,
   output logic       isJumping,
   output logic       attack_active,
   output logic       facing_right,
   output logic [2:0] state
);

   import fighter_pkg::*;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] air_q, air_d;
   logic             hit_pend_q, hit_pend_d;
   logic             atk_prev_q, atk_prev_d;
   logic             mv_left_q, mv_left_d;
   logic             mv_right_q, mv_right_d;
   logic             jump_q, jump_d;
   logic             atk_act_q, atk_act_d;
   logic             facing_q, facing_d;

   logic             tmr_load, tmr_dec, tmr_done_c;
   logic [CNT_W-1:0] tmr_val;

   logic             hit_now_c, atk_edge_c, dir_l_c, dir_r_c, on_floor_c;

   action_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (tmr_val),
      .done_c   (tmr_done_c)
   );

   // A hit arriving in the tick cycle itself counts for that tick
   assign hit_now_c  = hit_pend_q | hit_taken;
   assign atk_edge_c = btn_attack & ~atk_prev_q;
   assign dir_l_c    = btn_left & ~btn_right;
   assign dir_r_c    = btn_right & ~btn_left;
   assign on_floor_c = (sprite_y == Y_W'(FLOOR_Y));

   // Next-state and registered command logic; everything holds between ticks
   always_comb begin
      state_d    = state_q;
      air_d      = air_q;
      hit_pend_d = hit_now_c;
      atk_prev_d = atk_prev_q;
      mv_left_d  = mv_left_q;
      mv_right_d = mv_right_q;
      jump_d     = jump_q;
      atk_act_d  = atk_act_q;
      facing_d   = facing_q;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      tmr_val    = '0;

      if (tick) begin
         hit_pend_d = 1'b0;
         atk_prev_d = btn_attack;
         mv_left_d  = 1'b0;
         mv_right_d = 1'b0;
         jump_d     = 1'b0;
         atk_act_d  = 1'b0;

         if (health_zero || (state_q == ST_KO)) begin
            state_d = ST_KO;
         end else if (!enable) begin
            state_d = ST_IDLE;
         end else if (hit_now_c) begin
            state_d  = ST_STUN;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(STUN_TICKS);
         end else begin
            unique case (state_q)
               ST_IDLE, ST_WALK: begin
                  if (atk_edge_c) begin
                     state_d   = ST_ATTACK;
                     atk_act_d = 1'b1;
                     tmr_load  = 1'b1;
                     tmr_val   = CNT_W'(ATTACK_TICKS);
                  end else if (btn_jump && on_floor_c) begin
                     state_d = ST_AIRBORNE;
                     jump_d  = 1'b1;
                     air_d   = '0;
                  end else if (dir_l_c || dir_r_c) begin
                     state_d    = ST_WALK;
                     mv_left_d  = dir_l_c;
                     mv_right_d = dir_r_c;
                     facing_d   = dir_r_c;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               ST_AIRBORNE: begin
                  if (on_floor_c && (air_q >= CNT_W'(MIN_AIR_TICKS))) begin
                     state_d = ST_IDLE;
                  end else begin
                     mv_left_d  = dir_l_c;
                     mv_right_d = dir_r_c;
                     if (dir_l_c || dir_r_c) facing_d = dir_r_c;
                     if (air_q != CNT_MAX) air_d = air_q + CNT_W'(1);
                  end
               end
               ST_ATTACK: begin
                  tmr_dec = 1'b1;
                  if (tmr_done_c) state_d = ST_IDLE;
                  else            atk_act_d = 1'b1;
               end
               ST_STUN: begin
                  tmr_dec = 1'b1;
                  if (tmr_done_c) begin
                     if (on_floor_c) begin
                        state_d = ST_IDLE;
                     end else begin
                        state_d = ST_AIRBORNE;
                        air_d   = CNT_W'(MIN_AIR_TICKS);
                     end
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         air_q      <= '0;
         hit_pend_q <= 1'b0;
         atk_prev_q <= 1'b0;
         mv_left_q  <= 1'b0;
         mv_right_q <= 1'b0;
         jump_q     <= 1'b0;
         atk_act_q  <= 1'b0;
         facing_q   <= ~player_no;
      end else begin
         state_q    <= state_d;
         air_q      <= air_d;
         hit_pend_q <= hit_pend_d;
         atk_prev_q <= atk_prev_d;
         mv_left_q  <= mv_left_d;
         mv_right_q <= mv_right_d;
         jump_q     <= jump_d;
         atk_act_q  <= atk_act_d;
         facing_q   <= facing_d;
      end
   end

   assign movingLeft    = mv_left_q;
   assign movingRight   = mv_right_q;
   assign isJumping     = jump_q;
   assign attack_active = atk_act_q;
   assign facing_right  = facing_q;
   assign state         = state_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Scoreboard bench for player_action_ctrl: each tick pushes the expected
// output vector, and a monitor compares it on the falling edge after the tick.
module tb_player_action_ctrl;

   logic       clk = 1'b0;
   logic       reset, tick, enable, player_no;
   logic       btn_left, btn_right, btn_jump, btn_attack;
   logic [6:0] sprite_y;
   logic       hit_taken, health_zero;
   logic       movingLeft, movingRight, isJumping, attack_active, facing_right;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];
   logic       tick_seen = 1'b0;

   localparam logic [2:0] S_IDLE = 3'd0, S_WALK = 3'd1, S_AIR = 3'd2,
                          S_ATK  = 3'd3, S_STUN = 3'd4, S_KO  = 3'd5;

   player_action_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .enable        (enable),
      .player_no     (player_no),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_jump      (btn_jump),
      .btn_attack    (btn_attack),
      .sprite_y      (sprite_y),
      .hit_taken     (hit_taken),
      .health_zero   (health_zero),
      .movingLeft    (movingLeft),
      .movingRight   (movingRight),
      .isJumping     (isJumping),
      .attack_active (attack_active),
      .facing_right  (facing_right),
      .state         (state)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ev(input logic [2:0] st, input logic l, input logic r,
                                     input logic j, input logic a, input logic f);
      return {st, l, r, j, a, f};
   endfunction

   function automatic logic [7:0] outv();
      return {state, movingLeft, movingRight, isJumping, attack_active, facing_right};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: compare on the falling edge after every tick
   always @(posedge clk) tick_seen <= tick;
   always @(negedge clk) begin
      if (tick_seen) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_tick", 32'(outv()), 32'hFFFF_FFFF);
         end else begin
            check(tag_q.pop_front(), 32'(outv()), 32'(exp_q.pop_front()));
         end
      end
   end

   // One game tick with its expected post-tick output vector
   task automatic step(input string tag, input logic [7:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0; hit_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pulse_hit();
      @(posedge clk); #1 hit_taken = 1'b1;
      @(posedge clk); #1 hit_taken = 1'b0;
      #1;
   endtask

   task automatic do_reset(input logic pno);
      player_no = pno;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check("reset_state", 32'(outv()), 32'(ev(S_IDLE, 0, 0, 0, 0, ~pno)));
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; enable = 1'b1; player_no = 1'b1;
      btn_left = 0; btn_right = 0; btn_jump = 0; btn_attack = 0;
      sprite_y = 7'd48; hit_taken = 0; health_zero = 0;

      do_reset(1'b1);

      // Walking and direction conflicts
      btn_right = 1;
      for (int i = 0; i < 3; i++) step("walk_right", ev(S_WALK, 0, 1, 0, 0, 1));
      btn_left = 1;
      step("both_dirs", ev(S_IDLE, 0, 0, 0, 0, 1));
      btn_right = 0;
      step("walk_left", ev(S_WALK, 1, 0, 0, 0, 0));
      btn_left = 0;
      step("release", ev(S_IDLE, 0, 0, 0, 0, 0));

      // Jump, minimum air time, air control, landing
      btn_jump = 1;
      step("jump", ev(S_AIR, 0, 0, 1, 0, 0));
      btn_jump = 0;
      step("air_min", ev(S_AIR, 0, 0, 0, 0, 0));
      sprite_y = 7'd40; btn_right = 1;
      step("air_ctrl", ev(S_AIR, 0, 1, 0, 0, 1));
      sprite_y = 7'd48; btn_right = 0;
      step("land", ev(S_IDLE, 0, 0, 0, 0, 1));

      // Held attack: six active ticks, no retrigger
      btn_attack = 1;
      for (int i = 0; i < 6; i++) step("attack", ev(S_ATK, 0, 0, 0, 1, 1));
      for (int i = 0; i < 4; i++) step("atk_held", ev(S_IDLE, 0, 0, 0, 0, 1));
      btn_attack = 0;
      step("atk_release", ev(S_IDLE, 0, 0, 0, 0, 1));
      btn_attack = 1;
      step("atk_repress", ev(S_ATK, 0, 0, 0, 1, 1));
      btn_attack = 0;

      // Hit between ticks: no change until the tick, then STUN
      pulse_hit();
      check("hold_between_ticks", 32'(outv()), 32'(ev(S_ATK, 0, 0, 0, 1, 1)));
      step("stun_entry", ev(S_STUN, 0, 0, 0, 0, 1));
      for (int i = 0; i < 3; i++) step("stun", ev(S_STUN, 0, 0, 0, 0, 1));
      hit_taken = 1;  // coincides with the tick
      step("stun_rehit", ev(S_STUN, 0, 0, 0, 0, 1));
      for (int i = 0; i < 9; i++) step("stun_reload", ev(S_STUN, 0, 0, 0, 0, 1));
      step("stun_exit_floor", ev(S_IDLE, 0, 0, 0, 0, 1));

      // Stun ending in the air resumes AIRBORNE with minimum air time met
      sprite_y = 7'd40;
      pulse_hit();
      for (int i = 0; i < 10; i++) step("stun_air", ev(S_STUN, 0, 0, 0, 0, 1));
      step("stun_exit_air", ev(S_AIR, 0, 0, 0, 0, 1));
      sprite_y = 7'd48;
      step("stun_air_land", ev(S_IDLE, 0, 0, 0, 0, 1));

      // KO from AIRBORNE is sticky
      btn_jump = 1;
      step("jump2", ev(S_AIR, 0, 0, 1, 0, 1));
      btn_jump = 0; health_zero = 1;
      step("ko", ev(S_KO, 0, 0, 0, 0, 1));
      health_zero = 0; enable = 0;
      step("ko_en_low", ev(S_KO, 0, 0, 0, 0, 1));
      enable = 1; btn_left = 1;
      step("ko_en_high", ev(S_KO, 0, 0, 0, 0, 1));
      btn_left = 0;

      do_reset(1'b0);

      // enable low suppresses motion
      enable = 0; btn_left = 1;
      step("disabled", ev(S_IDLE, 0, 0, 0, 0, 1));
      enable = 1; btn_left = 0;

      // Async reset mid-air clears isJumping without a tick
      btn_jump = 1;
      step("jump3", ev(S_AIR, 0, 0, 1, 0, 1));
      btn_jump = 0;
      #3 reset = 1'b0;
      #1 check("async_reset", 32'(outv()), 32'(ev(S_IDLE, 0, 0, 0, 0, 1)));
      @(posedge clk); #1 reset = 1'b1;

      repeat (3) @(posedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
